i2c_write_ctrl: RTL and testbench
=================================

// Module: i2c_write_ctrl
// PURPOSE
//  Single-master I2C write sequencer for the i2c_master path. One request performs one
//  3-byte write: START, {dev_addr,W}, reg_addr, wr_data, STOP. Each byte is followed by
//  an ACK slot. Bit timing comes from an internal quarter-period tick.
//  SCL/SDA are open-drain enables that go to the top-level pads.
// PARAMETERS
//  DIV  125  ref_clk cycles per quarter SCL period (50MHz/(4*125)=100kHz); legal 2..65535
// PORTS
//  ref_clk   in   1  system clock, 50MHz
//  reset_n   in   1  asynchronous, active-low reset
//  start     in   1  request; sampled only when busy=0
//  dev_addr  in   7  7-bit slave address, latched on accept
//  reg_addr  in   8  register byte, latched on accept
//  wr_data   in   8  data byte, latched on accept
//  sda_i     in   1  SDA pad input, used for ACK sampling
//  scl_oe    out  1  1 = pull SCL low, 0 = release
//  sda_oe    out  1  1 = pull SDA low, 0 = release
//  busy      out  1  transaction in progress
//  done      out  1  one-cycle pulse at end of transaction
//  ack_err   out  1  NACK seen; sticky until next accepted start
// BEHAVIOUR
//  Reset (async): state=IDLE; scl_oe=0, sda_oe=0, busy=0, done=0, ack_err=0; counters cleared.
//  Accept: on an edge with state=IDLE and start=1, latch the 3 bytes, clear ack_err,
//   set busy=1, enter START. The quarter counter starts at 0. start while busy is ignored.
//  Tick: the 16-bit counter counts 0..DIV-1 while busy; tick=1 when count==DIV-1.
//   The counter is held at 0 in IDLE. All phase and state changes occur on tick edges only.
//  Quarter phases q0..q3 (2-bit, wrap): SCL low in q0,q1; SCL released in q2,q3.
//   No clock stretching: scl_i is not monitored.
//  Quarter-phase drive levels (SDA = level on the bus):
//   START: q0,q1 SCL=1 SDA=1; q2,q3 SCL=1 SDA=0.
//   BIT:   SDA = current bit (MSB first) for q0..q3; it changes only when entering q0.
//   ACK:   SDA released q0..q3; sda_i sampled on the tick that ends q2.
//   STOP:  q0..q2 SDA=0 (SCL 0,0,1); q3 SCL=1 SDA=1.
//  FSM: IDLE -> START -> BIT x8 -> ACK -> (next byte BIT | STOP) -> IDLE.
//   Byte index 0..2 selects {dev_addr,1'b0}, reg_addr, wr_data.
//   After the ACK of byte 2 -> STOP. A sample of sda_i=1 in any ACK -> ack_err=1;
//   at the end of that ACK slot go to STOP, and the remaining bytes are skipped.
//  End: the tick ending STOP q3 sets state=IDLE, busy=0 and done=1 for exactly one cycle.
//   The bus is left released (scl_oe=0, sda_oe=0).
//  Length: full write = 4+3*36+4 = 116 quarters, so done rises 116*DIV cycles after
//   the accept edge. NACK on byte n (0..2) = 4+36*(n+1)+4 quarters.
//  Latched bytes are immune to input changes mid-transfer.
//  reset_n low mid-transfer: both lines are released immediately and the FSM returns to IDLE.
//   No STOP is generated. No done pulse. The next start is accepted normally.
// TESTING
//  T1 reset: reset_n=0 at any time -> scl_oe=0, sda_oe=0, busy=0, done=0, ack_err=0.
//  T2 DIV=2, dev_addr=0x50, reg_addr=0x1A, wr_data=0xC3, slave ACKs
//     -> bytes sampled on SCL rise are 0xA0,0x1A,0xC3;
//     START/STOP edges are correct; done rises 232 cycles after accept; ack_err=0.
//  T3 DIV=2, sda_i=1 in the address ACK -> ack_err=1, STOP follows,
//     done 88 cycles after accept, no further bytes driven.
//  T4 DIV=2, NACK on the data byte -> ack_err=1, done at 232 cycles;
//     next start clears ack_err on accept.
//  T5 start pulsed and dev_addr/wr_data changed while busy -> ignored;
//     bytes on the bus unchanged; exactly one done.
//  T6 reset_n low mid-byte of reg_addr -> lines released same cycle, busy=0;
//     after release, a new start (DIV=2) completes as in T2.

Source files
------------

// File: rtl/i2c_write_ctrl_if.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// i2c_write_ctrl_if
// Groups the request handshake and the I2C pad signals of the write sequencer.
//   start     request, honoured only while busy=0
//   dev_addr  7-bit slave address
//   reg_addr  register byte
//   wr_data   data byte
//   sda_i     SDA pad input (ACK sampling)
//   scl_oe    1 = pull SCL low, 0 = release
//   sda_oe    1 = pull SDA low, 0 = release
//   busy      transaction in progress
//   done      one-cycle pulse at end of transaction
//   ack_err   sticky NACK flag, cleared by the next accepted start
// Modports: master = sequencer side, slave = requester / pad side.
// ---------------------------------------------------------------------------
interface i2c_write_ctrl_if;
  logic       start;
  logic [6:0] dev_addr;
  logic [7:0] reg_addr;
  logic [7:0] wr_data;
  logic       sda_i;
  logic       scl_oe;
  logic       sda_oe;
  logic       busy;
  logic       done;
  logic       ack_err;

  modport master (
    input  start, dev_addr, reg_addr, wr_data, sda_i,
    output scl_oe, sda_oe, busy, done, ack_err
  );

  modport slave (
    output start, dev_addr, reg_addr, wr_data, sda_i,
    input  scl_oe, sda_oe, busy, done, ack_err
  );
endinterface

// File: rtl/i2c_write_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// i2c_write_ctrl
// Single-master I2C write sequencer. One accepted request produces
// START, {dev_addr,W}, reg_addr, wr_data, STOP with an ACK slot after each
// byte. Every bus phase lasts one quarter SCL period of DIV ref_clk cycles.
// A NACK sets ack_err and cuts the transfer short with a STOP.
// Ports:
//   ref_clk  system clock
//   reset_n  asynchronous active-low reset (releases both lines at once)
//   bus      i2c_write_ctrl_if.master (request inputs, pad enables, status)
// ---------------------------------------------------------------------------
module i2c_write_ctrl #(
  parameter int DIV = 125
) (
  input  logic              ref_clk,
  input  logic              reset_n,
  i2c_write_ctrl_if.master  bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_BIT,
    ST_ACK,
    ST_STOP
  } state_t;

  localparam logic [15:0] LP_DIV_M1 = 16'(DIV - 1);

  state_t      r_state, w_state_nxt;
  logic [15:0] r_cnt;
  logic [1:0]  r_q, w_q_nxt;
  logic [2:0]  r_bit, w_bit_nxt;
  logic [1:0]  r_byte, w_byte_nxt;
  logic        r_ack_err, w_ack_err_nxt;
  logic        r_done, w_done_nxt;
  logic        r_busy;
  logic        r_scl_oe, r_sda_oe;
  logic        w_scl_oe_nxt, w_sda_oe_nxt;
  logic        w_tick, w_accept;
  logic [7:0]  w_byte_val;
  logic        w_bit_val;
  logic [6:0]  r_dev;
  logic [7:0]  r_reg, r_dat;

  // Pad enables for a given phase; returns {scl_oe, sda_oe}.
  // SCL is low in q0,q1 of every clocked phase; START keeps SCL high.
  function automatic logic [1:0] drive(input state_t st, input logic [1:0] q,
                                       input logic b);
    logic [1:0] r;
    r = 2'b00;
    case (st)
      ST_START: r = {1'b0, q[1]};
      ST_BIT:   r = {~q[1], ~b};
      ST_ACK:   r = {~q[1], 1'b0};
      ST_STOP:  r = {~q[1], (q != 2'd3)};
      default:  r = 2'b00;
    endcase
    return r;
  endfunction

  assign w_tick   = (r_state != ST_IDLE) && (r_cnt == LP_DIV_M1);
  assign w_accept = (r_state == ST_IDLE) && bus.start;

  always_comb begin
    w_state_nxt   = r_state;
    w_q_nxt       = r_q;
    w_bit_nxt     = r_bit;
    w_byte_nxt    = r_byte;
    w_ack_err_nxt = r_ack_err;
    w_done_nxt    = 1'b0;
    if (r_state == ST_IDLE) begin
      if (bus.start) begin
        w_state_nxt   = ST_START;
        w_q_nxt       = 2'd0;
        w_bit_nxt     = 3'd7;
        w_byte_nxt    = 2'd0;
        w_ack_err_nxt = 1'b0;
      end
    end else if (w_tick) begin
      w_q_nxt = r_q + 2'd1;
      case (r_state)
        ST_START: if (r_q == 2'd3) begin
          w_state_nxt = ST_BIT;
          w_bit_nxt   = 3'd7;
        end
        ST_BIT: if (r_q == 2'd3) begin
          if (r_bit == 3'd0) w_state_nxt = ST_ACK;
          else               w_bit_nxt   = r_bit - 3'd1;
        end
        ST_ACK: begin
          if ((r_q == 2'd2) && bus.sda_i) w_ack_err_nxt = 1'b1;
          // ack_err was registered at the q2 tick, so it is valid here.
          if (r_q == 2'd3) begin
            if (r_ack_err || (r_byte == 2'd2)) begin
              w_state_nxt = ST_STOP;
            end else begin
              w_state_nxt = ST_BIT;
              w_byte_nxt  = r_byte + 2'd1;
              w_bit_nxt   = 3'd7;
            end
          end
        end
        ST_STOP: if (r_q == 2'd3) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Pad enables are registered from the next phase so the pads never see
  // decode glitches.
  always_comb begin
    case (w_byte_nxt)
      2'd0:    w_byte_val = {r_dev, 1'b0};
      2'd1:    w_byte_val = r_reg;
      default: w_byte_val = r_dat;
    endcase
    w_bit_val = w_byte_val[w_bit_nxt];
    {w_scl_oe_nxt, w_sda_oe_nxt} = drive(w_state_nxt, w_q_nxt, w_bit_val);
  end

  always_ff @(posedge ref_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 16'd0;
      r_q       <= 2'd0;
      r_bit     <= 3'd7;
      r_byte    <= 2'd0;
      r_ack_err <= 1'b0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
      r_scl_oe  <= 1'b0;
      r_sda_oe  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_q       <= w_q_nxt;
      r_bit     <= w_bit_nxt;
      r_byte    <= w_byte_nxt;
      r_ack_err <= w_ack_err_nxt;
      r_done    <= w_done_nxt;
      r_busy    <= (w_state_nxt != ST_IDLE);
      r_scl_oe  <= w_scl_oe_nxt;
      r_sda_oe  <= w_sda_oe_nxt;
      if ((r_state == ST_IDLE) || w_tick) r_cnt <= 16'd0;
      else                                r_cnt <= r_cnt + 16'd1;
    end
  end

  // Request bytes are captured only on accept, so later input changes
  // cannot disturb a transfer in flight.
  always_ff @(posedge ref_clk) begin
    if (w_accept) begin
      r_dev <= bus.dev_addr;
      r_reg <= bus.reg_addr;
      r_dat <= bus.wr_data;
    end
  end

  assign bus.scl_oe  = r_scl_oe;
  assign bus.sda_oe  = r_sda_oe;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.ack_err = r_ack_err;

endmodule

// File: tb/tb_i2c_write_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_i2c_write_ctrl
// Bench for the I2C write sequencer with DIV=2. A behavioural bus slave
// decodes START/STOP conditions and bytes from the open-drain lines and
// ACKs or NACKs according to a per-transaction plan. Expected bytes,
// ACK bits, latency and ack_err are derived from the request and the plan.
// ---------------------------------------------------------------------------
module tb_i2c_write_ctrl;
  localparam int DIV = 2;

  logic ref_clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  i2c_write_ctrl_if bus();

  i2c_write_ctrl #(.DIV(DIV)) dut (
    .ref_clk (ref_clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 ref_clk = ~ref_clk;

  // Bus model: open-drain wired-AND of master and slave.
  bit   slave_pull;
  wire  w_scl = ~bus.scl_oe;
  assign bus.sda_i = ~(bus.sda_oe | slave_pull);
  wire  w_sda = bus.sda_i;

  bit       prev_scl, prev_sda;
  bit [7:0] shreg;
  int       bitcnt, byteidx;
  int       start_cnt, stop_cnt, done_cnt;
  int       nack_at = 3;
  logic [7:0] mon_bytes[$];
  logic       mon_acks[$];

  always @(negedge ref_clk) begin
    if (!reset_n) begin
      slave_pull <= 1'b0;
      bitcnt     <= 0;
      byteidx    <= 0;
      prev_scl   <= w_scl;
      prev_sda   <= w_sda;
    end else begin
      prev_scl <= w_scl;
      prev_sda <= w_sda;
      if (prev_scl && w_scl && prev_sda && !w_sda) begin
        start_cnt  <= start_cnt + 1;
        bitcnt     <= 0;
        byteidx    <= 0;
        slave_pull <= 1'b0;
      end else if (prev_scl && w_scl && !prev_sda && w_sda) begin
        stop_cnt <= stop_cnt + 1;
      end else if (!prev_scl && w_scl) begin
        if (bitcnt == 8) begin
          mon_bytes.push_back(shreg);
          mon_acks.push_back(w_sda);
        end
        shreg  <= {shreg[6:0], w_sda};
        bitcnt <= bitcnt + 1;
      end else if (prev_scl && !w_scl) begin
        if (bitcnt == 8) begin
          slave_pull <= (byteidx != nack_at);
        end else if (bitcnt == 9) begin
          slave_pull <= 1'b0;
          bitcnt     <= 0;
          byteidx    <= byteidx + 1;
        end
      end
    end
    if (bus.done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input int obs, input int exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  // One write; nack = index of the byte the slave refuses (3 = none).
  task automatic run_txn(input logic [6:0] dev, input logic [7:0] rg,
                         input logic [7:0] dat, input int nack,
                         input bit disturb);
    logic [7:0] exp_b[3];
    int nb, exp_lat, s0, p0, d0, b0, lat;
    bit seen;
    exp_b[0] = {dev, 1'b0};
    exp_b[1] = rg;
    exp_b[2] = dat;
    nb       = (nack < 3) ? nack + 1 : 3;
    exp_lat  = (4 + 36 * nb + 4) * DIV;
    @(negedge ref_clk);
    nack_at      = nack;
    bus.dev_addr = dev;
    bus.reg_addr = rg;
    bus.wr_data  = dat;
    bus.start    = 1'b1;
    s0 = start_cnt; p0 = stop_cnt; d0 = done_cnt; b0 = mon_bytes.size();
    seen = 1'b0;
    lat  = 0;
    for (int k = 1; k <= 2000 && !seen; k++) begin
      @(negedge ref_clk);
      if (k == 1) begin
        bus.start = 1'b0;
        check("busy_after_accept", int'(bus.busy), 1);
        check("ack_err_cleared_on_accept", int'(bus.ack_err), 0);
      end
      if (disturb && k == 20) begin
        bus.start    = 1'b1;
        bus.dev_addr = ~dev;
        bus.reg_addr = ~rg;
        bus.wr_data  = ~dat;
      end
      if (disturb && k == 22) bus.start = 1'b0;
      if (bus.done) begin
        seen = 1'b1;
        lat  = k - 1;
      end
    end
    check("done_seen", int'(seen), 1);
    check("done_latency", lat, exp_lat);
    check("ack_err_final", int'(bus.ack_err), int'(nack < 3));
    @(negedge ref_clk);
    check("done_one_cycle", int'(bus.done), 0);
    check("busy_clear", int'(bus.busy), 0);
    check("scl_released", int'(bus.scl_oe), 0);
    check("sda_released", int'(bus.sda_oe), 0);
    check("start_cond_count", start_cnt - s0, 1);
    check("stop_cond_count", stop_cnt - p0, 1);
    check("done_pulse_count", done_cnt - d0, 1);
    check("bytes_on_bus", mon_bytes.size() - b0, nb);
    for (int i = 0; i < nb; i++) begin
      if (b0 + i < mon_bytes.size()) begin
        check($sformatf("byte%0d", i), int'(mon_bytes[b0 + i]), int'(exp_b[i]));
        check($sformatf("ack_bit%0d", i), int'(mon_acks[b0 + i]), int'(i == nack));
      end
    end
    if (disturb) begin
      repeat (10) @(negedge ref_clk);
      check("no_second_txn_busy", int'(bus.busy), 0);
      check("no_second_done", done_cnt - d0, 1);
    end
  endtask

  initial begin
    int d0;
    logic [6:0] rd;
    logic [7:0] rr, rw;
    int rn;
    bus.start    = 1'b0;
    bus.dev_addr = 7'h00;
    bus.reg_addr = 8'h00;
    bus.wr_data  = 8'h00;

    // T1: reset state
    repeat (3) @(negedge ref_clk);
    check("rst_scl_oe", int'(bus.scl_oe), 0);
    check("rst_sda_oe", int'(bus.sda_oe), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_ack_err", int'(bus.ack_err), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge ref_clk);

    // T2: full write, all ACKed
    run_txn(7'h50, 8'h1A, 8'hC3, 3, 1'b0);
    // T3: NACK on address byte
    run_txn(7'h50, 8'h1A, 8'hC3, 0, 1'b0);
    // T4: NACK on data byte, then a clean write clears ack_err on accept
    run_txn(7'h3C, 8'h05, 8'h7E, 2, 1'b0);
    run_txn(7'h3C, 8'h05, 8'h7E, 3, 1'b0);
    // T5: start and inputs disturbed mid-transfer
    run_txn(7'h2A, 8'h10, 8'h99, 3, 1'b1);

    // T6: async reset in the middle of the reg_addr byte
    @(negedge ref_clk);
    nack_at      = 3;
    bus.dev_addr = 7'h11;
    bus.reg_addr = 8'h5A;
    bus.wr_data  = 8'h0F;
    bus.start    = 1'b1;
    @(negedge ref_clk);
    bus.start = 1'b0;
    repeat (96) @(negedge ref_clk);
    check("t6_busy_mid_byte", int'(bus.busy), 1);
    check("t6_scl_low_mid_byte", int'(bus.scl_oe), 1);
    d0 = done_cnt;
    @(posedge ref_clk);
    #1 reset_n = 1'b0;
    #1;
    check("t6_scl_released", int'(bus.scl_oe), 0);
    check("t6_sda_released", int'(bus.sda_oe), 0);
    check("t6_busy", int'(bus.busy), 0);
    check("t6_done", int'(bus.done), 0);
    check("t6_ack_err", int'(bus.ack_err), 0);
    repeat (3) @(negedge ref_clk);
    reset_n = 1'b1;
    repeat (2) @(negedge ref_clk);
    check("t6_no_done_pulse", done_cnt - d0, 0);
    run_txn(7'h50, 8'h1A, 8'hC3, 3, 1'b0);

    // Randomized requests and ACK plans
    for (int t = 0; t < 8; t++) begin
      rd = 7'($urandom_range(0, 127));
      rr = 8'($urandom_range(0, 255));
      rw = 8'($urandom_range(0, 255));
      rn = int'($urandom_range(0, 5));
      if (rn > 3) rn = 3;
      run_txn(rd, rr, rw, rn, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
